// File: rtl/univ_shift_burst_reg.sv
`default_nettype none
// ============================================================================
// Module   : univ_shift_burst_reg
// Purpose  : Universal shift register with parallel load, logical / rotate /
//            arithmetic shift modes, serial-out capture and an N-position
//            burst shift run under a start/busy/done handshake with abort.
// Ports    : clk    - clock, rising edge
//            rstn   - synchronous reset, active-low
//            load   - parallel load request (IDLE only)
//            din    - parallel load data [WIDTH]
//            start  - burst start request (IDLE only, load wins)
//            mode   - shift mode [3], latched at start
//            count  - number of 1-bit shifts [CNT_W], latched at start
//            sin    - serial input, sampled on each shifting edge
//            abort  - terminates a burst in SHIFT, no shift on that edge
//            dout   - register contents [WIDTH]
//            sout   - last bit shifted / rotated out
//            busy   - high while in SHIFT
//            done   - one-cycle completion pulse
//            parity - ^dout, registered (only with USR_PARITY_EN)
// Options  : `define USR_PARITY_EN adds the parity output.
// Revision : 1.0 - initial release
// ============================================================================
module univ_shift_burst_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic             sin,
  input  logic             abort,
  output logic [WIDTH-1:0] dout,
  output logic             sout,
  output logic             busy,
  output logic             done
`ifdef USR_PARITY_EN
  ,
  output logic             parity
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dout_q,  dout_d;
  logic             sout_q,  sout_d;
  logic [2:0]       mode_q,  mode_d;
  logic [CNT_W-1:0] rem_q,   rem_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      dout_q  <= '0;
      sout_q  <= 1'b0;
      mode_q  <= 3'd0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      sout_q  <= sout_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    sout_d  = sout_q;
    mode_d  = mode_q;
    rem_d   = rem_q;

    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          dout_d = din;
        end else if (start) begin
          mode_d = mode;
          rem_d  = count;
          // A zero-length burst still produces the done pulse.
          state_d = (count != '0) ? S_SHIFT : S_DONE;
        end
      end

      S_SHIFT: begin
        if (abort) begin
          // Partially shifted contents are kept as-is.
          state_d = S_IDLE;
        end else begin
          case (mode_q)
            3'd0: begin
              dout_d = {dout_q[WIDTH-2:0], sin};
              sout_d = dout_q[WIDTH-1];
            end
            3'd1: begin
              dout_d = {sin, dout_q[WIDTH-1:1]};
              sout_d = dout_q[0];
            end
            3'd2: begin
              dout_d = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
              sout_d = dout_q[WIDTH-1];
            end
            3'd3: begin
              dout_d = {dout_q[0], dout_q[WIDTH-1:1]};
              sout_d = dout_q[0];
            end
            3'd4: begin
              dout_d = {dout_q[WIDTH-1], dout_q[WIDTH-1:1]};
              sout_d = dout_q[0];
            end
            3'd5: begin
              dout_d = {dout_q[WIDTH-2:0], 1'b0};
              sout_d = dout_q[WIDTH-1];
            end
            // Reserved modes hold data but still run the burst timing.
            default: begin
              dout_d = dout_q;
              sout_d = sout_q;
            end
          endcase
          rem_d = rem_q - 1'b1;
          if (rem_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign dout = dout_q;
  assign sout = sout_q;
  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);

`ifdef USR_PARITY_EN
  logic parity_q, parity_d;

  // Tracks dout exactly: recomputed from the next-state data every edge.
  always_comb begin
    parity_d = ^dout_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity = parity_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_burst_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_univ_shift_burst_reg
// Purpose  : Directed self-checking bench for univ_shift_burst_reg (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_univ_shift_burst_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rstn;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             start;
  logic [2:0]       mode;
  logic [CNT_W-1:0] count;
  logic             sin;
  logic             abort;
  logic [WIDTH-1:0] dout;
  logic             sout;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  univ_shift_burst_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .load  (load),
    .din   (din),
    .start (start),
    .mode  (mode),
    .count (count),
    .sin   (sin),
    .abort (abort),
    .dout  (dout),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] val);
    load = 1'b1;
    din  = val;
    tick();
    load = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] m, input logic [CNT_W-1:0] c);
    start = 1'b1;
    mode  = m;
    count = c;
    tick();
    start = 1'b0;
  endtask

  int busy_cycles;

  initial begin
    rstn = 1'b0; load = 1'b0; din = '0; start = 1'b0;
    mode = 3'd0; count = '0; sin = 1'b0; abort = 1'b0;
    tick();
    tick();
    check("rst_dout", dout, 0);
    check("rst_sout", sout, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rstn = 1'b1;

    // 1: logical left, sin=1, three shifts from 0xA5
    do_load(8'hA5);
    check("t1_load", dout, 8'hA5);
    sin = 1'b1;
    do_start(3'd0, 4'd3);
    check("t1_e0_busy", busy, 1);
    check("t1_e0_dout", dout, 8'hA5);
    tick();
    check("t1_e1_dout", dout, 8'h4B);
    check("t1_e1_sout", sout, 1);
    tick();
    check("t1_e2_dout", dout, 8'h97);
    check("t1_e2_sout", sout, 0);
    tick();
    check("t1_e3_dout", dout, 8'h2F);
    check("t1_e3_sout", sout, 1);
    check("t1_e3_busy", busy, 0);
    check("t1_e3_done", done, 1);
    tick();
    check("t1_idle_done", done, 0);
    check("t1_idle_busy", busy, 0);

    // 2: arithmetic right from 0x90
    sin = 1'b0;
    do_load(8'h90);
    do_start(3'd4, 4'd2);
    tick();
    check("t2_e1_dout", dout, 8'hC8);
    check("t2_e1_busy", busy, 1);
    tick();
    check("t2_e2_dout", dout, 8'hE4);
    check("t2_e2_sout", sout, 0);
    check("t2_e2_done", done, 1);

    // 3: rotate right by 9 wraps past WIDTH; sout holds through load
    tick();
    do_load(8'h81);
    check("t3_load_sout_hold", sout, 0);
    do_start(3'd3, 4'd9);
    busy_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy) busy_cycles++;
      tick();
    end
    check("t3_after8_dout", dout, 8'h81);
    for (int i = 0; i < 20 && busy; i++) begin
      busy_cycles++;
      tick();
    end
    check("t3_busy_cycles", busy_cycles, 9);
    check("t3_final_dout", dout, 8'hC0);
    check("t3_final_sout", sout, 1);
    check("t3_done", done, 1);

    // 4: zero-length burst
    tick();
    do_load(8'h3C);
    do_start(3'd1, 4'd0);
    check("t4_busy", busy, 0);
    check("t4_done", done, 1);
    check("t4_dout", dout, 8'h3C);
    tick();
    check("t4_done_clr", done, 0);
    check("t4_dout_hold", dout, 8'h3C);

    // 5: rotate left, abort after two shifts; load during busy ignored
    do_load(8'h01);
    do_start(3'd2, 4'd5);
    load = 1'b1;
    din  = 8'hFF;
    tick();
    check("t5_e1_dout", dout, 8'h02);
    tick();
    check("t5_e2_dout", dout, 8'h04);
    load  = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_abort_dout", dout, 8'h04);
    check("t5_abort_busy", busy, 0);
    check("t5_abort_done", done, 0);
    check("t5_abort_sout", sout, 0);
    tick();
    check("t5_no_late_done", done, 0);

    // Arithmetic left ignores sin
    do_load(8'h81);
    sin = 1'b1;
    do_start(3'd5, 4'd1);
    tick();
    check("m5_dout", dout, 8'h02);
    check("m5_sout", sout, 1);
    check("m5_done", done, 1);
    tick();

    // Reserved mode holds data but keeps burst timing
    do_start(3'd6, 4'd2);
    tick();
    check("m6_e1_dout", dout, 8'h02);
    check("m6_e1_busy", busy, 1);
    tick();
    check("m6_e2_dout", dout, 8'h02);
    check("m6_e2_sout", sout, 1);
    check("m6_e2_done", done, 1);
    tick();

    // 6: reset mid-burst, then a fresh burst
    sin = 1'b1;
    do_start(3'd0, 4'd7);
    tick();
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("t6_rst_dout", dout, 0);
    check("t6_rst_sout", sout, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    do_start(3'd1, 4'd1);
    check("t6_fresh_busy", busy, 1);
    tick();
    check("t6_fresh_dout", dout, 8'h80);
    check("t6_fresh_done", done, 1);
    tick();

    // load and start together: only the load happens
    load  = 1'b1;
    din   = 8'h55;
    start = 1'b1;
    mode  = 3'd0;
    count = 4'd3;
    tick();
    load  = 1'b0;
    start = 1'b0;
    check("t6_prio_dout", dout, 8'h55);
    check("t6_prio_busy", busy, 0);
    check("t6_prio_done", done, 0);
    tick();
    check("t6_prio_busy2", busy, 0);
    check("t6_prio_dout2", dout, 8'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
